wb_pipe_stage: RTL and testbench
================================

// Module: wb_pipe_stage
// PURPOSE
//  Parametrised MEM->WB pipeline register, successor to the fixed single-stage latch.
//  Chain of STAGES skid-buffered slots with valid/ready handshake, synchronous flush,
//  $zero write masking, occupancy count and a saturating back-pressure stall counter.
//  Sits between the data-memory stage and the register-file write port; forwarding
//  taps feed the hazard unit.
// PARAMETERS
//  STAGES      1   number of chained slots (>=1); latency in cycles with no back-pressure
//  PAYLOAD_W   128 opaque payload width (ReadData, ALUOut, PCPlus4, Instr = 4x32)
//  CTRL_W      2   opaque control bits carried with payload (MemtoReg, Link)
//  REG_W       5   destination register index width
//  ZERO_MASK   1   1: force regwrite=0 when wreg==0
//  STALL_W     16  stall counter width
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          synchronous, active-high reset
//  flush         in   1          synchronous kill of all in-flight entries
//  in_valid      in   1          upstream entry valid
//  in_ready      out  1          slot 0 can accept (registered, = !skid_valid[0])
//  in_regwrite   in   1          RegWrite of incoming entry
//  in_wreg       in   REG_W      destination register
//  in_ctrl       in   CTRL_W     control bits
//  in_payload    in   PAYLOAD_W  data payload
//  out_valid     out  1          head entry valid
//  out_ready     in   1          downstream accepts head
//  out_regwrite  out  1          RegWrite, already ANDed with out_valid
//  out_wreg      out  REG_W      destination register of head
//  out_ctrl      out  CTRL_W     head control bits
//  out_payload   out  PAYLOAD_W  head payload
//  occupancy     out  $clog2(2*STAGES+1)  count of valid main+skid entries
//  stall_cnt     out  STALL_W    cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  - Reset: all valid/skid bits 0, regwrite 0, wreg/ctrl/payload 0, occupancy 0,
//    stall_cnt 0; in_ready=1 first cycle after reset. rst has priority over flush.
//  - Slot = main reg + skid reg. Accept when up_valid && up_ready. Main advances when
//    main empty or down_ready; it reloads from skid if skid valid, else from accepted input.
//    Input arriving while main held (not draining) goes to skid; skid full -> ready=0.
//  - up_ready is a register output (no combinational ready path); no entry ever dropped
//    or duplicated under any valid/ready pattern.
//  - Latency: STAGES cycles from accept to out_valid when out_ready held 1; full
//    throughput 1 entry/cycle.
//  - Order preserved (FIFO); max capacity 2*STAGES.
//  - ZERO_MASK: regwrite cleared at slot-0 capture if in_wreg==0; entry still travels.
//  - flush: next cycle all valid, skid and regwrite bits 0; input presented on flush
//    cycle is discarded even if in_ready=1; in_ready=1 next cycle. stall_cnt not cleared.
//  - flush during back-pressure: held head dropped, out_valid=0 next cycle.
//  - occupancy: registered, updated same edge as valid bits; 0..2*STAGES.
//  - stall_cnt: +1 each cycle out_valid && !out_ready; holds at 2^STALL_W-1;
//    cleared only by rst.
//  - Payload/ctrl/wreg of invalid slots don't care except after rst (0).
// STRUCTURE
//  - Shared package wb_pkg: default widths (REG_W=5, DATA_W=32), payload field offsets
//    (RDATA, ALUOUT, PC4, INSTR), ctrl bit indices (MEMTOREG, LINK).
//  - Sub-module skid_slot (one main+skid pair, valid/ready, flush); top instantiates
//    STAGES copies in a generate loop, adds zero-mask, occupancy and stall counter.
// TESTING
//  - rst 3 cycles, STAGES=2, out_ready=1, stream 8 entries payload=i -> out in order,
//    first out_valid exactly 2 cycles after first accept, no gaps.
//  - out_ready=0 with continuous input -> in_ready falls after exactly 4 accepts,
//    occupancy=4, stall_cnt increments each held cycle; release -> 4 entries out in order.
//  - flush with occupancy=3 and in_valid=1 -> next cycle occupancy=0, out_valid=0,
//    in_ready=1; flushed-cycle input never appears at output.
//  - in_wreg=0, in_regwrite=1 -> out_regwrite=0, out_payload still delivered;
//    in_wreg=7 -> out_regwrite=1.
//  - STALL_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt saturates at 15.
//  - rst asserted together with flush mid-stream -> all outputs reset values,
//    stall_cnt=0.
//  - Random valid/ready (both 50%), 10k entries vs scoreboard -> no loss/dup/reorder.

Source files
------------

// File: rtl/wb_pipe_stage_pkg.sv
// Shared widths, payload field offsets and control-bit indices for the MEM->WB boundary.
package wb_pkg;

  localparam int WB_DATA_W    = 32;
  localparam int WB_REG_W     = 5;
  localparam int WB_NFIELDS   = 4;
  localparam int WB_PAYLOAD_W = WB_NFIELDS * WB_DATA_W;
  localparam int WB_CTRL_W    = 2;

  // Payload is {Instr, PCPlus4, ALUOut, ReadData}, lowest field first.
  localparam int RDATA_LSB  = 0;
  localparam int ALUOUT_LSB = 1 * WB_DATA_W;
  localparam int PC4_LSB    = 2 * WB_DATA_W;
  localparam int INSTR_LSB  = 3 * WB_DATA_W;

  localparam int MEMTOREG = 0;
  localparam int LINK     = 1;

  typedef enum logic [1:0] {
    F_RDATA  = 2'd0,
    F_ALUOUT = 2'd1,
    F_PC4    = 2'd2,
    F_INSTR  = 2'd3
  } field_e;

  function automatic logic [WB_DATA_W-1:0] get_field(input logic [WB_PAYLOAD_W-1:0] p,
                                                      input field_e f);
    return p[int'(f)*WB_DATA_W +: WB_DATA_W];
  endfunction

endpackage

// File: rtl/wb_pipe_stage_skid_slot.sv
// One main+skid register pair with a registered ready and a synchronous flush.
module skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic         up_rw,
  input  logic [W-1:0] up_data,
  output logic         down_valid,
  input  logic         down_ready,
  output logic         down_rw,
  output logic [W-1:0] down_data
);

  logic         main_v, skid_v;
  logic         main_rw, skid_rw;
  logic [W-1:0] main_d, skid_d;
  logic         accept, adv;

  // Ready comes straight from the skid flag, so no combinational path runs upstream.
  assign up_ready   = !skid_v;
  assign accept     = up_valid && !skid_v;
  assign adv        = !main_v || down_ready;

  assign down_valid = main_v;
  assign down_rw    = main_rw;
  assign down_data  = main_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      main_rw <= 1'b0;
      skid_rw <= 1'b0;
      main_d  <= '0;
      skid_d  <= '0;
    end else if (flush) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      main_rw <= 1'b0;
      skid_rw <= 1'b0;
    end else if (adv) begin
      // Skid holds the older entry, so it always wins the reload.
      if (skid_v) begin
        main_v  <= 1'b1;
        main_rw <= skid_rw;
        main_d  <= skid_d;
        skid_v  <= 1'b0;
        skid_rw <= 1'b0;
      end else begin
        main_v  <= accept;
        main_rw <= accept && up_rw;
        if (accept) main_d <= up_data;
      end
    end else if (accept) begin
      skid_v  <= 1'b1;
      skid_rw <= up_rw;
      skid_d  <= up_data;
    end
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register: STAGES chained skid slots plus $zero masking,
// occupancy tracking and a saturating back-pressure stall counter.
module wb_pipe_stage
  import wb_pkg::*;
#(
  parameter int STAGES    = 1,
  parameter int PAYLOAD_W = WB_PAYLOAD_W,
  parameter int CTRL_W    = WB_CTRL_W,
  parameter int REG_W     = WB_REG_W,
  parameter int ZERO_MASK = 1,
  parameter int STALL_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_regwrite,
  input  logic [REG_W-1:0]                 in_wreg,
  input  logic [CTRL_W-1:0]                in_ctrl,
  input  logic [PAYLOAD_W-1:0]             in_payload,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_regwrite,
  output logic [REG_W-1:0]                 out_wreg,
  output logic [CTRL_W-1:0]                out_ctrl,
  output logic [PAYLOAD_W-1:0]             out_payload,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy,
  output logic [STALL_W-1:0]               stall_cnt
);

  localparam int W     = REG_W + CTRL_W + PAYLOAD_W;
  localparam int OCC_W = $clog2(2*STAGES+1);

  function automatic logic mask_rw(input logic rw, input logic [REG_W-1:0] wreg);
    return rw && !((ZERO_MASK != 0) && (wreg == '0));
  endfunction

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] c);
    return (&c) ? c : c + STALL_W'(1);
  endfunction

  // Index i is the boundary feeding slot i; index STAGES is the output.
  logic [STAGES:0]        vld;
  logic [STAGES:0]        rdy;
  logic [STAGES:0]        rw;
  logic [STAGES:0][W-1:0] dat;

  assign vld[0]      = in_valid;
  assign rw[0]       = mask_rw(in_regwrite, in_wreg);
  assign dat[0]      = {in_wreg, in_ctrl, in_payload};
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    skid_slot #(.W(W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (vld[i]),
      .up_ready   (rdy[i]),
      .up_rw      (rw[i]),
      .up_data    (dat[i]),
      .down_valid (vld[i+1]),
      .down_ready (rdy[i+1]),
      .down_rw    (rw[i+1]),
      .down_data  (dat[i+1])
    );
  end

  assign out_valid    = vld[STAGES];
  assign out_regwrite = vld[STAGES] && rw[STAGES];
  assign {out_wreg, out_ctrl, out_payload} = dat[STAGES];

  logic             in_fire, out_fire;
  logic [OCC_W-1:0] occ_q;
  logic [STALL_W-1:0] stall_q;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

  // Inter-slot moves conserve the total, so only the two ends change the count.
  always_ff @(posedge clk) begin
    if (rst || flush) occ_q <= '0;
    else              occ_q <= occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
  end

  always_ff @(posedge clk) begin
    if (rst)                          stall_q <= '0;
    else if (out_valid && !out_ready) stall_q <= sat_inc(stall_q);
  end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed and randomized checks of wb_pipe_stage with STAGES=2, STALL_W=4.
module tb_wb_pipe_stage;

  localparam int STAGES    = 2;
  localparam int PAYLOAD_W = 128;
  localparam int CTRL_W    = 2;
  localparam int REG_W     = 5;
  localparam int STALL_W   = 4;
  localparam int OCC_W     = $clog2(2*STAGES+1);
  localparam int N_RAND    = 10000;

  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic                 in_valid, in_ready, in_regwrite;
  logic [REG_W-1:0]     in_wreg;
  logic [CTRL_W-1:0]    in_ctrl;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid, out_ready, out_regwrite;
  logic [REG_W-1:0]     out_wreg;
  logic [CTRL_W-1:0]    out_ctrl;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [OCC_W-1:0]     occupancy;
  logic [STALL_W-1:0]   stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic                 rw;
    logic [REG_W-1:0]     wreg;
    logic [CTRL_W-1:0]    ctrl;
    logic [PAYLOAD_W-1:0] payload;
  } ent_t;

  always #5 clk = ~clk;

  wb_pipe_stage #(
    .STAGES(STAGES), .PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W),
    .REG_W(REG_W), .ZERO_MASK(1), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
    .in_wreg(in_wreg), .in_ctrl(in_ctrl), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_regwrite(out_regwrite),
    .out_wreg(out_wreg), .out_ctrl(out_ctrl), .out_payload(out_payload),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0;
    in_wreg = '0; in_ctrl = '0; in_payload = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_chk++; if (out_regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got=%b want=0", out_regwrite); end
    n_chk++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
    n_chk++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
    n_chk++; if (out_payload !== '0) begin n_fail++; $display("FAIL reset_payload got=%h want=0", out_payload); end
    n_chk++; if (out_wreg !== '0 || out_ctrl !== '0) begin n_fail++; $display("FAIL reset_wreg_ctrl got=%0d/%0d want=0/0", out_wreg, out_ctrl); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got = 0;
    int first_acc = -1;
    int first_out = -1;
    out_ready = 1'b1;
    in_regwrite = 1'b1; in_wreg = 5'd3; in_ctrl = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (first_out >= 0 || out_valid) begin
        if (first_out < 0) first_out = c;
        n_chk++;
        if (!out_valid) begin
          n_fail++; $display("FAIL stream_gap cycle=%0d out_valid=0 want=1", c);
        end else begin
          if (out_payload !== PAYLOAD_W'(got)) begin
            n_fail++; $display("FAIL stream_order got=%0d want=%0d", out_payload, got);
          end
          got++;
        end
      end
      if (sent < 8) begin
        in_valid = 1'b1; in_payload = PAYLOAD_W'(sent);
        if (in_ready) begin
          if (first_acc < 0) first_acc = c;
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++; if (got != 8) begin n_fail++; $display("FAIL stream_count got=%0d want=8", got); end
    n_chk++; if (first_out - first_acc != 2) begin n_fail++; $display("FAIL stream_latency got=%0d want=2", first_out - first_acc); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    out_ready = 1'b0;
    in_regwrite = 1'b1; in_wreg = 5'd4; in_ctrl = '0;
    for (int c = 0; c < 10; c++) begin
      if (!in_ready) break;
      in_valid = 1'b1; in_payload = PAYLOAD_W'(100 + acc);
      acc++;
      @(negedge clk);
    end
    in_payload = PAYLOAD_W'(999);
    n_chk++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepts got=%0d want=4", acc); end
    n_chk++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occupancy got=%0d want=4", occupancy); end
    n_chk++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL bp_stall_start got=%0d want=2", stall_cnt); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_chk++; if (stall_cnt !== STALL_W'(2 + k)) begin n_fail++; $display("FAIL bp_stall_inc got=%0d want=%0d", stall_cnt, 2 + k); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (out_valid) begin
        n_chk++;
        if (out_payload !== PAYLOAD_W'(100 + got)) begin
          n_fail++; $display("FAIL bp_order got=%0d want=%0d", out_payload, 100 + got);
        end
        got++;
      end
      @(negedge clk);
    end
    n_chk++; if (got != 4) begin n_fail++; $display("FAIL bp_drain got=%0d want=4", got); end
    n_chk++; if (occupancy !== '0) begin n_fail++; $display("FAIL bp_empty got=%0d want=0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_fill_ready got=%b want=1", in_ready); end
      in_valid = 1'b1; in_payload = PAYLOAD_W'(200 + k);
      @(negedge clk);
    end
    n_chk++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ got=%0d want=3", occupancy); end
    flush = 1'b1; in_valid = 1'b1; in_payload = PAYLOAD_W'(16'hDEAD);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (occupancy !== '0) begin n_fail++; $display("FAIL flush_occ got=%0d want=0", occupancy); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
    n_chk++; if (out_regwrite !== 1'b0) begin n_fail++; $display("FAIL flush_regwrite got=%b want=0", out_regwrite); end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak got=%b payload=%h want=no output", out_valid, out_payload); end
    end
  endtask

  task automatic test_zero_mask();
    out_ready = 1'b1;
    in_valid = 1'b1; in_regwrite = 1'b1; in_wreg = 5'd0; in_ctrl = 2'b10; in_payload = PAYLOAD_W'(8'h55);
    @(negedge clk);
    in_wreg = 5'd7; in_ctrl = 2'b01; in_payload = PAYLOAD_W'(8'h77);
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zm0_valid got=%b want=1", out_valid); end
    n_chk++; if (out_regwrite !== 1'b0) begin n_fail++; $display("FAIL zm0_regwrite got=%b want=0", out_regwrite); end
    n_chk++; if (out_payload !== PAYLOAD_W'(8'h55)) begin n_fail++; $display("FAIL zm0_payload got=%h want=55", out_payload); end
    n_chk++; if (out_ctrl !== 2'b10) begin n_fail++; $display("FAIL zm0_ctrl got=%b want=10", out_ctrl); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zm7_valid got=%b want=1", out_valid); end
    n_chk++; if (out_regwrite !== 1'b1) begin n_fail++; $display("FAIL zm7_regwrite got=%b want=1", out_regwrite); end
    n_chk++; if (out_wreg !== 5'd7) begin n_fail++; $display("FAIL zm7_wreg got=%0d want=7", out_wreg); end
    n_chk++; if (out_payload !== PAYLOAD_W'(8'h77)) begin n_fail++; $display("FAIL zm7_payload got=%h want=77", out_payload); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || out_regwrite !== 1'b0) begin n_fail++; $display("FAIL zm_idle got=%b/%b want=0/0", out_valid, out_regwrite); end
  endtask

  task automatic test_stall_sat();
    out_ready = 1'b0;
    in_valid = 1'b1; in_regwrite = 1'b0; in_wreg = 5'd1; in_payload = PAYLOAD_W'(300);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (22) @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid got=%b want=1", out_valid); end
    n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_value got=%0d want=15", stall_cnt); end
    @(negedge clk);
    n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got=%0d want=15", stall_cnt); end
  endtask

  task automatic test_rst_flush();
    in_valid = 1'b1; in_regwrite = 1'b1; in_wreg = 5'd9; in_ctrl = 2'b11; in_payload = PAYLOAD_W'(301);
    @(negedge clk);
    rst = 1'b1; flush = 1'b1; in_payload = PAYLOAD_W'(302);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_out_valid got=%b want=0", out_valid); end
    n_chk++; if (out_regwrite !== 1'b0) begin n_fail++; $display("FAIL rf_regwrite got=%b want=0", out_regwrite); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rf_in_ready got=%b want=1", in_ready); end
    n_chk++; if (occupancy !== '0) begin n_fail++; $display("FAIL rf_occ got=%0d want=0", occupancy); end
    n_chk++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL rf_stall got=%0d want=0", stall_cnt); end
    n_chk++; if (out_payload !== '0) begin n_fail++; $display("FAIL rf_payload got=%h want=0", out_payload); end
    n_chk++; if (out_wreg !== '0 || out_ctrl !== '0) begin n_fail++; $display("FAIL rf_wreg_ctrl got=%0d/%0d want=0/0", out_wreg, out_ctrl); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    ent_t exp_e;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 60000 && got < N_RAND; c++) begin
      n_chk++;
      if (occupancy !== OCC_W'(q.size())) begin
        n_fail++; $display("FAIL rand_occ cycle=%0d got=%0d want=%0d", c, occupancy, q.size());
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_dup payload=%h want=no entry", out_payload);
        end else begin
          exp_e = q.pop_front();
          if ({out_regwrite, out_wreg, out_ctrl, out_payload} !== exp_e) begin
            n_fail++; $display("FAIL rand_entry got=%h want=%h", {out_regwrite, out_wreg, out_ctrl, out_payload}, exp_e);
          end
        end
        got++;
      end
      in_valid = (sent < N_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_regwrite = 1'($urandom_range(0, 1));
      in_wreg = REG_W'($urandom_range(0, 31));
      in_ctrl = CTRL_W'($urandom_range(0, 3));
      in_payload = {$urandom, $urandom, $urandom, 32'(sent)};
      if (in_valid && in_ready) begin
        e.rw = in_regwrite && (in_wreg != '0);
        e.wreg = in_wreg; e.ctrl = in_ctrl; e.payload = in_payload;
        q.push_back(e);
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++; if (got != N_RAND) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", got, N_RAND); end
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_residue got=%0d want=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_zero_mask();
    test_stall_sat();
    test_rst_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
